// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS fetch front end.
package mips_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WAIT  = 2'd2,
        FULL  = 2'd3
    } fetch_state_t;

    localparam int PC_INC          = 4;
    localparam int ADDR_W_DEFAULT  = 32;
    localparam int INSTR_W_DEFAULT = 32;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC select: a redirect wins over sequential advance, otherwise the PC holds.
module pc_next_sel
    import mips_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_target,
    input  logic              advance,
    output logic [ADDR_W-1:0] pc_next
);

    always_comb begin
        pc_next = pc;
        if (redirect_valid) begin
            // Instructions are word aligned; the low target bits carry no meaning.
            pc_next = redirect_target & ~ADDR_W'(3);
        end else if (advance) begin
            pc_next = pc + ADDR_W'(PC_INC);
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: one outstanding imem request, one-entry output buffer.
//   IDLE  | just out of reset, fetch starts next cycle
//   FETCH | request pc, waiting for imem_req_ready
//   WAIT  | request accepted, waiting for the response (dropped if squash)
//   FULL  | instruction buffered, waiting for decode
module fetch_sequencer
    import mips_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_W_DEFAULT,
    parameter int                INSTR_W  = INSTR_W_DEFAULT,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [ADDR_W-1:0]  imem_req_addr,
    input  logic               imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_data,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_target,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ADDR_W-1:0]  out_pc,
    output logic [INSTR_W-1:0] out_instr
);

    fetch_state_t      state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_next;
    logic [ADDR_W-1:0] inflight_pc;
    logic              squash;
    logic              advance;

    assign advance        = (state == WAIT) && imem_rsp_valid && !squash;
    assign imem_req_valid = (state == FETCH);
    assign imem_req_addr  = pc;

    pc_next_sel #(.ADDR_W(ADDR_W)) u_pc_next_sel (
        .pc              (pc),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .advance         (advance),
        .pc_next         (pc_next)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            inflight_pc <= RESET_PC;
            squash      <= 1'b0;
            out_valid   <= 1'b0;
            out_pc      <= '0;
            out_instr   <= '0;
        end else begin
            pc <= pc_next;
            if (redirect_valid) begin
                out_valid <= 1'b0;
            end
            case (state)
                IDLE: state <= FETCH;
                FETCH: begin
                    if (imem_req_ready) begin
                        inflight_pc <= pc;
                        squash      <= redirect_valid;
                        state       <= WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rsp_valid) begin
                        // A redirect landing with the response kills it too; staying
                        // in WAIT would wait for a response that already came.
                        if (squash || redirect_valid) begin
                            squash <= 1'b0;
                            state  <= FETCH;
                        end else begin
                            out_instr <= imem_rsp_data;
                            out_pc    <= inflight_pc;
                            out_valid <= 1'b1;
                            state     <= FULL;
                        end
                    end else if (redirect_valid) begin
                        squash <= 1'b1;
                    end
                end
                FULL: begin
                    if (redirect_valid || out_ready) begin
                        out_valid <= 1'b0;
                        state     <= FETCH;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed vector table, hand-written redirect/reset
// sequences, and a randomized run against a transaction-level reference model.
module tb_fetch_sequencer;

    logic        clk;
    logic        reset;
    logic        imem_req_valid, imem_req_ready, imem_rsp_valid;
    logic [31:0] imem_req_addr, imem_rsp_data;
    logic        redirect_valid, out_valid, out_ready;
    logic [31:0] redirect_target, out_pc, out_instr;

    logic        w_reset;
    logic        w_req_valid, w_req_ready, w_rsp_valid;
    logic [31:0] w_req_addr, w_rsp_data;
    logic        w_redirect_valid, w_out_valid, w_out_ready;
    logic [31:0] w_redirect_target, w_out_pc, w_out_instr;

    int n_checks = 0;
    int n_errors = 0;

    fetch_sequencer #(.ADDR_W(32), .INSTR_W(32), .RESET_PC(32'h0)) dut (
        .clk(clk), .reset(reset),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .redirect_valid(redirect_valid),
        .redirect_target(redirect_target), .out_valid(out_valid),
        .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr)
    );

    fetch_sequencer #(.ADDR_W(32), .INSTR_W(32), .RESET_PC(32'hFFFF_FFFC)) dut_w (
        .clk(clk), .reset(w_reset),
        .imem_req_valid(w_req_valid), .imem_req_ready(w_req_ready),
        .imem_req_addr(w_req_addr), .imem_rsp_valid(w_rsp_valid),
        .imem_rsp_data(w_rsp_data), .redirect_valid(w_redirect_valid),
        .redirect_target(w_redirect_target), .out_valid(w_out_valid),
        .out_ready(w_out_ready), .out_pc(w_out_pc), .out_instr(w_out_instr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached, got %0d checks, required completion", n_checks);
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic drive(input bit r, input bit rs, input logic [31:0] d,
                         input bit rd, input logic [31:0] t, input bit o);
        imem_req_ready  = r;
        imem_rsp_valid  = rs;
        imem_rsp_data   = d;
        redirect_valid  = rd;
        redirect_target = t;
        out_ready       = o;
    endtask

    task automatic step(input bit r, input bit rs, input logic [31:0] d,
                        input bit rd, input logic [31:0] t, input bit o);
        drive(r, rs, d, rd, t, o);
        @(negedge clk);
    endtask

    task automatic w_step(input bit r, input bit rs, input logic [31:0] d, input bit o);
        w_req_ready = r;
        w_rsp_valid = rs;
        w_rsp_data  = d;
        w_out_ready = o;
        @(negedge clk);
    endtask

    task automatic main_reset();
        @(negedge clk);
        reset = 1'b1;
        drive(0, 0, 32'h0, 0, 32'h0, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    typedef struct {
        bit          r, rs, rd, o;
        logic [31:0] d, t;
        bit          e_rv, e_ov;
        logic [31:0] e_addr, e_pc, e_instr;
    } vec_t;

    function automatic vec_t mk(bit r, bit rs, logic [31:0] d, bit rd, logic [31:0] t, bit o,
                                bit erv, logic [31:0] ea, bit eov, logic [31:0] ep, logic [31:0] ei);
        vec_t v;
        v.r = r; v.rs = rs; v.d = d; v.rd = rd; v.t = t; v.o = o;
        v.e_rv = erv; v.e_addr = ea; v.e_ov = eov; v.e_pc = ep; v.e_instr = ei;
        return v;
    endfunction

    localparam logic [31:0] D0 = 32'h2408_0001, D1 = 32'h2409_0002, D2 = 32'h8D0A_0004;
    localparam logic [31:0] D3 = 32'hAC0B_0008, D4 = 32'h1000_FFFF, D5 = 32'h0800_0040;
    localparam logic [31:0] DX = 32'hDEAD_BEEF;

    vec_t vecs[16];

    // transaction-level reference model state
    logic [31:0] m_pc, o_addr, b_pc, b_instr, rnd_d, rnd_t;
    bit          o_pend, o_stale, b_valid, rnd_r, rnd_rs, rnd_rd, rnd_o, acc, hs;
    int          o_delay, deliveries;

    initial begin
        reset   = 1'b1;
        w_reset = 1'b1;
        drive(0, 0, 32'h0, 0, 32'h0, 0);
        w_req_ready = 0; w_rsp_valid = 0; w_rsp_data = 0; w_out_ready = 0;
        w_redirect_valid = 0; w_redirect_target = 0;

        // free run from reset, then a 5-cycle decode stall on the 0x4 instruction
        vecs[0]  = mk(1, 0, 0,  0, 0, 1,  0, 32'h0, 0, 32'h0, 32'h0);
        vecs[1]  = mk(1, 0, 0,  0, 0, 1,  1, 32'h0, 0, 32'h0, 32'h0);
        vecs[2]  = mk(0, 1, D0, 0, 0, 1,  0, 32'h0, 0, 32'h0, 32'h0);
        vecs[3]  = mk(0, 0, 0,  0, 0, 1,  0, 32'h4, 1, 32'h0, D0);
        vecs[4]  = mk(1, 0, 0,  0, 0, 1,  1, 32'h4, 0, 32'h0, 32'h0);
        vecs[5]  = mk(0, 1, D1, 0, 0, 1,  0, 32'h4, 0, 32'h0, 32'h0);
        for (int i = 6; i <= 10; i++)
            vecs[i] = mk(1, 0, 0, 0, 0, 0,  0, 32'h8, 1, 32'h4, D1);
        vecs[11] = mk(1, 0, 0,  0, 0, 1,  0, 32'h8, 1, 32'h4, D1);
        vecs[12] = mk(1, 0, 0,  0, 0, 1,  1, 32'h8, 0, 32'h0, 32'h0);
        vecs[13] = mk(0, 1, D2, 0, 0, 1,  0, 32'h8, 0, 32'h0, 32'h0);
        vecs[14] = mk(0, 0, 0,  0, 0, 1,  0, 32'hC, 1, 32'h8, D2);
        vecs[15] = mk(0, 0, 0,  0, 0, 1,  1, 32'hC, 0, 32'h0, 32'h0);

        main_reset();
        check("reset_out_pc", out_pc, 32'h0);
        check("reset_out_instr", out_instr, 32'h0);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("vec%0d_req_valid", i), imem_req_valid, vecs[i].e_rv);
            check($sformatf("vec%0d_req_addr", i), imem_req_addr, vecs[i].e_addr);
            check($sformatf("vec%0d_out_valid", i), out_valid, vecs[i].e_ov);
            if (vecs[i].e_ov) begin
                check($sformatf("vec%0d_out_pc", i), out_pc, vecs[i].e_pc);
                check($sformatf("vec%0d_out_instr", i), out_instr, vecs[i].e_instr);
            end
            step(vecs[i].r, vecs[i].rs, vecs[i].d, vecs[i].rd, vecs[i].t, vecs[i].o);
        end

        // redirect while the 0x10 fetch is outstanding
        step(1, 0, 0, 0, 0, 1);
        step(0, 1, D3, 0, 0, 1);
        check("seqA_buf_pc", out_pc, 32'hC);
        check("seqA_buf_instr", out_instr, D3);
        step(0, 0, 0, 0, 0, 1);
        check("seqA_req_addr_10", imem_req_addr, 32'h10);
        step(1, 0, 0, 0, 0, 1);
        step(0, 0, 0, 1, 32'h0000_0103, 1);
        check("seqA_addr_after_redirect", imem_req_addr, 32'h100);
        check("seqA_no_req_in_wait", imem_req_valid, 1'b0);
        step(0, 1, DX, 0, 0, 1);
        check("seqA_squashed_out_valid", out_valid, 1'b0);
        check("seqA_refetch_valid", imem_req_valid, 1'b1);
        check("seqA_refetch_addr", imem_req_addr, 32'h100);

        // redirect in the same cycle the 0x20 fetch is accepted
        step(0, 0, 0, 1, 32'h20, 1);
        check("seqB_fetch_20", imem_req_addr, 32'h20);
        step(1, 0, 0, 1, 32'h200, 1);
        check("seqB_addr_200", imem_req_addr, 32'h200);
        check("seqB_wait", imem_req_valid, 1'b0);
        step(0, 1, DX, 0, 0, 1);
        check("seqB_squashed_out_valid", out_valid, 1'b0);
        check("seqB_refetch_addr", imem_req_addr, 32'h200);
        check("seqB_refetch_valid", imem_req_valid, 1'b1);
        step(1, 0, 0, 0, 0, 0);
        step(0, 1, D4, 0, 0, 0);
        check("seqB_out_pc", out_pc, 32'h200);
        check("seqB_out_instr", out_instr, D4);
        check("seqB_next_pc", imem_req_addr, 32'h204);
        // redirect in FULL drops the buffer
        step(0, 0, 0, 1, 32'h43, 1);
        check("seqC_out_valid", out_valid, 1'b0);
        check("seqC_req_valid", imem_req_valid, 1'b1);
        check("seqC_req_addr", imem_req_addr, 32'h40);

        // PC wrap and mid-operation reset on the RESET_PC=0xFFFF_FFFC instance
        w_reset = 1'b0;
        check("wrap_reset_addr", w_req_addr, 32'hFFFF_FFFC);
        check("wrap_reset_req_valid", w_req_valid, 1'b0);
        w_step(0, 0, 0, 1);
        check("wrap_first_req", w_req_valid, 1'b1);
        check("wrap_first_addr", w_req_addr, 32'hFFFF_FFFC);
        w_step(1, 0, 0, 1);
        w_step(0, 1, D5, 0);
        check("wrap_out_pc", w_out_pc, 32'hFFFF_FFFC);
        check("wrap_out_instr", w_out_instr, D5);
        w_step(0, 0, 0, 1);
        check("wrap_second_addr", w_req_addr, 32'h0);
        check("wrap_second_valid", w_req_valid, 1'b1);
        w_step(1, 0, 0, 1);
        w_reset = 1'b1;
        @(negedge clk);
        check("midrst_req_valid", w_req_valid, 1'b0);
        check("midrst_req_addr", w_req_addr, 32'hFFFF_FFFC);
        check("midrst_out_valid", w_out_valid, 1'b0);
        check("midrst_out_pc", w_out_pc, 32'h0);
        check("midrst_out_instr", w_out_instr, 32'h0);
        w_reset = 1'b0;
        w_step(0, 1, DX, 1);
        check("stray_idle_out_valid", w_out_valid, 1'b0);
        check("stray_idle_fetch", w_req_valid, 1'b1);
        w_step(0, 1, DX, 1);
        check("stray_fetch_out_valid", w_out_valid, 1'b0);
        check("stray_fetch_addr", w_req_addr, 32'hFFFF_FFFC);

        // randomized run against the reference model
        main_reset();
        m_pc = 32'h0; o_pend = 0; o_stale = 0; b_valid = 0; o_delay = 0; deliveries = 0;
        o_addr = 0; b_pc = 0; b_instr = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            check("rnd_out_valid", out_valid, b_valid);
            if (b_valid && out_valid) begin
                check("rnd_out_pc", out_pc, b_pc);
                check("rnd_out_instr", out_instr, b_instr);
            end
            if (imem_req_valid) begin
                check("rnd_req_addr", imem_req_addr, m_pc);
                check("rnd_single_outstanding", o_pend || b_valid, 1'b0);
            end
            rnd_r  = ($urandom % 4) != 0;
            rnd_rs = 0;
            if (o_pend) begin
                if (o_delay <= 1) rnd_rs = 1;
                else o_delay--;
            end
            rnd_d  = $urandom;
            rnd_rd = ($urandom % 10) == 0;
            rnd_t  = (($urandom % 4) == 0) ? (32'hFFFF_FFF0 | 32'($urandom % 16)) : $urandom;
            rnd_o  = ($urandom % 3) != 0;
            drive(rnd_r, rnd_rs, rnd_d, rnd_rd, rnd_t, rnd_o);
            acc = imem_req_valid && rnd_r;
            hs  = out_valid && rnd_o;
            if (hs) begin
                deliveries++;
                b_valid = 0;
            end
            if (rnd_rs) begin
                o_pend = 0;
                if (!o_stale && !rnd_rd) begin
                    b_valid = 1; b_pc = o_addr; b_instr = rnd_d; m_pc = m_pc + 32'd4;
                end
                o_stale = 0;
            end
            if (acc) begin
                o_pend = 1; o_addr = m_pc; o_stale = 0;
                o_delay = int'($urandom_range(1, 3));
            end
            if (rnd_rd) begin
                m_pc = rnd_t & ~32'd3;
                b_valid = 0;
                if (o_pend) o_stale = 1;
            end
            @(negedge clk);
        end
        check("rnd_progress", deliveries >= 100, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

- Instruction-fetch controller for the MIPS core.
- Owns the architectural PC register and issues one instruction-memory request at a time over a valid/ready handshake.
- Holds each returned instruction in a one-entry output buffer until decode accepts it.
- Sits between the PC-next datapath (increment / branch select) and the decode stage, and applies branch/jump redirects, squashing any in-flight fetch.

## Interface
Parameters:
- ADDR_W, 32, PC and memory address width
- INSTR_W, 32, instruction width
- RESET_PC, 0, PC after reset; bits [1:0] must be 0

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  ADDR_W  fetch address, always equal to the current PC
- imem_rsp_valid  in  1  response valid, at most one per accepted request, ≥1 cycle after acceptance
- imem_rsp_data  in  INSTR_W  fetched instruction
- redirect_valid  in  1  branch/jump taken, single-cycle pulse
- redirect_target  in  ADDR_W  new PC; bits [1:0] ignored and forced to 0
- out_valid  out  1  buffered instruction valid
- out_ready  in  1  decode accepts, low while decode is stalled
- out_pc  out  ADDR_W  PC of the buffered instruction
- out_instr  out  INSTR_W  buffered instruction

## Operation
FSM states, in package type fetch_state_t:
- **IDLE**: entered on reset; moves to FETCH on the next cycle.
- **FETCH**: imem_req_valid = 1. When imem_req_ready = 1, latch inflight_pc = pc and go to WAIT.
- **WAIT**: wait for imem_rsp_valid.
  - If squash = 0: out_instr <= rsp_data, out_pc <= inflight_pc, out_valid <= 1, pc <= pc + 4, go to FULL.
  - If squash = 1: discard the response, clear squash, go to FETCH.
- **FULL**: hold the buffer. When out_valid & out_ready: out_valid <= 0, go to FETCH.

Redirect (redirect_valid = 1) has priority over every other transition:
- pc <= {redirect_target[ADDR_W-1:2], 2'b00}; out_valid <= 0.
- IDLE: state unchanged (still moves to FETCH).
- FETCH with no acceptance that cycle: stay in FETCH; the next request uses the new PC.
- FETCH with acceptance that cycle: go to WAIT with squash = 1.
- WAIT: stay in WAIT, squash <= 1; the pending response is discarded.
- FULL: go to FETCH. If out_ready is also high that cycle, the handshake counts as completed: decode owns that instruction.
- A second redirect while squash = 1: only the PC is updated; squash stays 1.

Other rules:
- Only one request is ever outstanding.
- imem_req_valid stays high in FETCH until accepted; imem_req_addr is stable while valid is high, except on a redirect cycle.
- PC arithmetic is modulo 2^ADDR_W: 0xFFFF_FFFC + 4 wraps to 0.
- imem_rsp_valid outside WAIT is ignored.

Reset values:
- state = IDLE, pc = RESET_PC, squash = 0
- imem_req_valid = 0, imem_req_addr = RESET_PC
- out_valid = 0, out_pc = 0, out_instr = 0

Reset asserted mid-operation aborts everything, including a pending squash, and produces the values above on the next cycle. A later stray response lands in IDLE/FETCH and is ignored.

## Timing
- imem_req_valid is decoded from the registered state; imem_req_addr comes from the pc register; no combinational input→output paths.
- First request is issued in the 2nd cycle after reset deasserts.
- Best-case steady throughput is one instruction per 3 cycles: FETCH accepted → WAIT with response → FULL consumed.
- out_valid rises in the cycle after imem_rsp_valid.
- A redirect takes effect on imem_req_addr in the cycle after redirect_valid.
- out_valid falls in the cycle after a redirect.

## Structure
- Package mips_pkg holds:
  - fetch_state_t enum {IDLE, FETCH, WAIT, FULL}
  - localparam PC_INC = 4
  - the default ADDR_W/INSTR_W values
- One combinational sub-module, pc_next_sel, computes the next PC from the inputs pc, redirect_valid, redirect_target and advance. Priority: redirect, then pc + PC_INC, then hold.
- All other logic (FSM, squash flag, output buffer) lives in fetch_sequencer.

## Test plan
- **Reset then free-run:** memory always ready, 1-cycle response, out_ready = 1. Expect requests at 0x0, 0x4, 0x8 and out_pc sequence 0x0, 0x4, 0x8, one instruction every 3 cycles.
- **Decode stall:** out_ready = 0 for 5 cycles with an instruction at 0x4 buffered. Expect out_valid, out_pc = 0x4 and out_instr held stable, no new request, then FETCH of 0x8 the cycle after out_ready rises.
- **Redirect during WAIT:** redirect 0x0000_0103 while a fetch of 0x10 is outstanding. Expect the response for 0x10 dropped, out_valid to stay 0, and the next request at 0x100.
- **Redirect on acceptance cycle:** redirect 0x200 in the same cycle the fetch of 0x20 is accepted. Expect the 0x20 response squashed and the next request at 0x200.
- **Wrap and mid-operation reset:** RESET_PC = 0xFFFF_FFFC; expect fetches of 0xFFFF_FFFC then 0x0. Then assert reset while in WAIT; expect all outputs back to reset values and a later stray imem_rsp_valid to produce no out_valid.
